// File: rtl/au_add_core_if.sv
// ---------------------------------------------------------------------------
// au_add_core_if -- operand/result bundle for the au_add_core wrap-around adder.
//
// Parameters:
//   WIDTH : operand and sum word length in bits (1..64)
//
// Signals:
//   a  : augend, driven by the master
//   b  : addend, driven by the master
//   s  : registered sum (a + b) mod 2^WIDTH, driven by the adder
//   co : registered carry out of bit WIDTH-1, driven by the adder
//        (present only when AU_ADD_COUT_EN is defined)
//
// Modports:
//   master : operand source / result sink
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface au_add_core_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
`ifdef AU_ADD_COUT_EN
    logic             co;
`endif

`ifdef AU_ADD_COUT_EN
    modport master (output a, output b, input  s, input  co);
    modport slave  (input  a, input  b, output s, output co);
`else
    modport master (output a, output b, input  s);
    modport slave  (input  a, input  b, output s);
`endif

endinterface

// File: rtl/au_add_core.sv
// ---------------------------------------------------------------------------
// au_add_core -- two-operand binary adder, sum modulo 2^WIDTH, registered.
//
// Parameters:
//   WIDTH : operand/sum width in bits, 1..64
//   ARCH  : carry network: 0 ripple, 1 Sklansky, 2 Kogge-Stone,
//           3 Brent-Kung, anything else ripple. All produce identical sums.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, clears the result register(s)
//   bus  : au_add_core_if.slave -- a, b in; s (and co) out, 1-cycle latency
//
// Optional build macro:
//   AU_ADD_COUT_EN : adds registered carry-out bus.co (bit WIDTH of a + b).
//                    Without it the top prefix node is never built.
// ---------------------------------------------------------------------------
module au_add_core #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic          clk,
    input  logic          rst,
    au_add_core_if.slave  bus
);

    // Number of prefix levels; zero for the single-bit degenerate case.
    localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 0;

    // Highest node index + 1 whose group carry is actually needed.
`ifdef AU_ADD_COUT_EN
    localparam int NB = WIDTH;
`else
    localparam int NB = WIDTH - 1;
`endif

    // Associative (g,p) combine of a high group with the adjacent low group.
    function automatic logic [1:0] pg_combine(input logic gh, input logic ph,
                                              input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] cy_s;   // carry into each bit, cy_s[0] = 0
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
`ifdef AU_ADD_COUT_EN
    logic             co_s;
    logic             co_d;
    logic             co_q;
`endif

    assign g_s = bus.a & bus.b;
    assign p_s = bus.a ^ bus.b;

    // Carry network: turns per-bit (g,p) into group generates gv[i] = carry
    // out of bits [i:0]. Nodes are updated in place; every node read at a
    // level is one that the same level does not overwrite (or, for ripple
    // and Kogge-Stone, one at a lower index visited later in a descending
    // loop / earlier in an ascending one), so one vector per level suffices.
    always_comb begin : carry_net
        logic [WIDTH-1:0] gv;
        logic [WIDTH-1:0] pv;
        logic [1:0]       gp;
        int               d;
        gv   = g_s;
        pv   = p_s;
        gp   = 2'b00;
        d    = 0;
        cy_s = '0;
`ifdef AU_ADD_COUT_EN
        co_s = 1'b0;
`endif
        case (ARCH)
            32'sd1: begin
                // Sklansky: at level k, nodes with index bit k set absorb the
                // top node of the lower half of their 2^(k+1) block.
                for (int k = 0; k < LV; k++) begin
                    for (int i = NB - 1; i >= 1; i--) begin
                        if (((i >> k) & 32'sd1) == 32'sd1) begin
                            d  = ((i >> k) << k) - 32'sd1;
                            gp = pg_combine(gv[i], pv[i], gv[d], pv[d]);
                        end else begin
                            gp = {gv[i], pv[i]};
                        end
                        gv[i] = gp[1];
                        pv[i] = gp[0];
                    end
                end
            end
            32'sd2: begin
                // Kogge-Stone: every node combines with the node 2^k below.
                for (int k = 0; k < LV; k++) begin
                    d = 32'sd1 << k;
                    for (int i = NB - 1; i >= 1; i--) begin
                        if (i >= d) begin
                            gp = pg_combine(gv[i], pv[i], gv[i-d], pv[i-d]);
                        end else begin
                            gp = {gv[i], pv[i]};
                        end
                        gv[i] = gp[1];
                        pv[i] = gp[0];
                    end
                end
            end
            32'sd3: begin
                // Brent-Kung up-sweep: build power-of-two aligned groups.
                for (int k = 0; k < LV; k++) begin
                    d = 32'sd1 << k;
                    for (int i = NB - 1; i >= 1; i--) begin
                        if (((i + 32'sd1) % (32'sd2 * d)) == 32'sd0) begin
                            gp = pg_combine(gv[i], pv[i], gv[i-d], pv[i-d]);
                        end else begin
                            gp = {gv[i], pv[i]};
                        end
                        gv[i] = gp[1];
                        pv[i] = gp[0];
                    end
                end
                // Down-sweep: fill the remaining nodes from finished prefixes.
                for (int k = LV - 1; k >= 0; k--) begin
                    d = 32'sd1 << k;
                    for (int i = NB - 1; i >= 1; i--) begin
                        if ((((i + 32'sd1) % (32'sd2 * d)) == d) && (i >= (32'sd2 * d))) begin
                            gp = pg_combine(gv[i], pv[i], gv[i-d], pv[i-d]);
                        end else begin
                            gp = {gv[i], pv[i]};
                        end
                        gv[i] = gp[1];
                        pv[i] = gp[0];
                    end
                end
            end
            default: begin
                // Ripple: serial chain from bit 0 upward.
                for (int i = 1; i < NB; i++) begin
                    gv[i] = g_s[i] | (p_s[i] & gv[i-1]);
                end
            end
        endcase
        for (int i = 1; i < WIDTH; i++) begin
            cy_s[i] = gv[i-1];
        end
`ifdef AU_ADD_COUT_EN
        co_s = gv[WIDTH-1];
`endif
    end

    assign s_d = p_s ^ cy_s;
`ifdef AU_ADD_COUT_EN
    assign co_d = co_s;
`endif

    // Result register: cleared by reset, otherwise captures this cycle's sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

`ifdef AU_ADD_COUT_EN
    // Carry-out register, same timing and reset as the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            co_q <= 1'b0;
        end else begin
            co_q <= co_d;
        end
    end

    assign bus.co = co_q;
`endif

    assign bus.s = s_q;

endmodule

// File: tb/tb_au_add_core.sv
// ---------------------------------------------------------------------------
// tb_au_add_core -- self-checking bench for au_add_core.
// Instantiates WIDTH = 1, 8, 13, 32, each with ARCH = 0, 1, 2, 3, 7, all fed
// from shared per-width operands. Each cycle every instance is compared with
// a plain-arithmetic reference ((a + b) wide, then truncated).
// ---------------------------------------------------------------------------
module tb_au_add_core;

    localparam int NA = 5;   // ARCH values 0,1,2,3,7

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [0:0]  a1,  b1;
    logic [7:0]  a8,  b8;
    logic [12:0] a13, b13;
    logic [31:0] a32, b32;

    logic [0:0]  s1  [NA];
    logic [7:0]  s8  [NA];
    logic [12:0] s13 [NA];
    logic [31:0] s32 [NA];
`ifdef AU_ADD_COUT_EN
    logic co1 [NA], co8 [NA], co13 [NA], co32 [NA];
`endif

    for (genvar k = 0; k < NA; k++) begin : g1
        au_add_core_if #(.WIDTH(1)) bus ();
        assign bus.a = a1;
        assign bus.b = b1;
        assign s1[k] = bus.s;
`ifdef AU_ADD_COUT_EN
        assign co1[k] = bus.co;
`endif
        au_add_core #(.WIDTH(1), .ARCH((k == 4) ? 7 : k)) dut (.clk(clk), .rst(rst), .bus(bus));
    end

    for (genvar k = 0; k < NA; k++) begin : g8
        au_add_core_if #(.WIDTH(8)) bus ();
        assign bus.a = a8;
        assign bus.b = b8;
        assign s8[k] = bus.s;
`ifdef AU_ADD_COUT_EN
        assign co8[k] = bus.co;
`endif
        au_add_core #(.WIDTH(8), .ARCH((k == 4) ? 7 : k)) dut (.clk(clk), .rst(rst), .bus(bus));
    end

    for (genvar k = 0; k < NA; k++) begin : g13
        au_add_core_if #(.WIDTH(13)) bus ();
        assign bus.a = a13;
        assign bus.b = b13;
        assign s13[k] = bus.s;
`ifdef AU_ADD_COUT_EN
        assign co13[k] = bus.co;
`endif
        au_add_core #(.WIDTH(13), .ARCH((k == 4) ? 7 : k)) dut (.clk(clk), .rst(rst), .bus(bus));
    end

    for (genvar k = 0; k < NA; k++) begin : g32
        au_add_core_if #(.WIDTH(32)) bus ();
        assign bus.a = a32;
        assign bus.b = b32;
        assign s32[k] = bus.s;
`ifdef AU_ADD_COUT_EN
        assign co32[k] = bus.co;
`endif
        au_add_core #(.WIDTH(32), .ARCH((k == 4) ? 7 : k)) dut (.clk(clk), .rst(rst), .bus(bus));
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer sum, carry is bit WIDTH of the result.
    function automatic logic [64:0] add_ref(input logic [63:0] x, input logic [63:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Compare every instance against the reference for the inputs present
    // before the edge just taken (inputs are held until after this check).
    task automatic check_model();
        logic [64:0] r1, r8, r13, r32;
        r1  = rst ? 65'd0 : add_ref(64'(a1),  64'(b1));
        r8  = rst ? 65'd0 : add_ref(64'(a8),  64'(b8));
        r13 = rst ? 65'd0 : add_ref(64'(a13), 64'(b13));
        r32 = rst ? 65'd0 : add_ref(64'(a32), 64'(b32));
        for (int k = 0; k < NA; k++) begin
            chk($sformatf("w1_arch%0d_s", k),  64'(s1[k]),  64'(r1[0:0]));
            chk($sformatf("w8_arch%0d_s", k),  64'(s8[k]),  64'(r8[7:0]));
            chk($sformatf("w13_arch%0d_s", k), 64'(s13[k]), 64'(r13[12:0]));
            chk($sformatf("w32_arch%0d_s", k), 64'(s32[k]), 64'(r32[31:0]));
`ifdef AU_ADD_COUT_EN
            chk($sformatf("w1_arch%0d_co", k),  64'(co1[k]),  64'(r1[1]));
            chk($sformatf("w8_arch%0d_co", k),  64'(co8[k]),  64'(r8[8]));
            chk($sformatf("w13_arch%0d_co", k), 64'(co13[k]), 64'(r13[13]));
            chk($sformatf("w32_arch%0d_co", k), 64'(co32[k]), 64'(r32[32]));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       co;
    } v8_t;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic co;
    } v1_t;

    v8_t t8 [14];
    v1_t t1 [4];

    initial begin
        logic [31:0] r;

        // Reset, corner values, then back-to-back stream with a mid-stream reset.
        t8[0]  = '{1'b1, 8'hA5, 8'h3C, 8'h00, 1'b0};
        t8[1]  = '{1'b1, 8'hA5, 8'h3C, 8'h00, 1'b0};
        t8[2]  = '{1'b0, 8'hA5, 8'h3C, 8'hE1, 1'b0};
        t8[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        t8[4]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0};
        t8[5]  = '{1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0};
        t8[6]  = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        t8[7]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        t8[8]  = '{1'b0, 8'h01, 8'h02, 8'h03, 1'b0};
        t8[9]  = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        t8[10] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0};
        t8[11] = '{1'b0, 8'h01, 8'h02, 8'h03, 1'b0};
        t8[12] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b0};
        t8[13] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0};

        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
        t1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        t1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        a1 = 1'b0;  b1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        a13 = 13'h0; b13 = 13'h0;
        a32 = 32'h0; b32 = 32'h0;

        // Table: WIDTH=8 against fixed expectations (and the model for all).
        for (int n = 0; n < 14; n++) begin
            rst = t8[n].rst;
            a8  = t8[n].a;
            b8  = t8[n].b;
            step();
            for (int k = 0; k < NA; k++) begin
                chk($sformatf("tab8_row%0d_arch%0d_s", n, k), 64'(s8[k]), 64'(t8[n].s));
`ifdef AU_ADD_COUT_EN
                chk($sformatf("tab8_row%0d_arch%0d_co", n, k), 64'(co8[k]), 64'(t8[n].co));
`endif
            end
        end

        // Table: WIDTH=1 truth table.
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            a1 = t1[n].a;
            b1 = t1[n].b;
            step();
            for (int k = 0; k < NA; k++) begin
                chk($sformatf("tab1_row%0d_arch%0d_s", n, k), 64'(s1[k]), 64'(t1[n].s));
`ifdef AU_ADD_COUT_EN
                chk($sformatf("tab1_row%0d_arch%0d_co", n, k), 64'(co1[k]), 64'(t1[n].co));
`endif
            end
        end

        // All-zero / all-one operand pairs on every width.
        for (int c = 0; c < 4; c++) begin
            a1  = {1{c[1]}};  b1  = {1{c[0]}};
            a8  = {8{c[1]}};  b8  = {8{c[0]}};
            a13 = {13{c[1]}}; b13 = {13{c[0]}};
            a32 = {32{c[1]}}; b32 = {32{c[0]}};
            step();
        end

        // Random streaming with occasional reset pulses.
        for (int n = 0; n < 4000; n++) begin
            r   = $urandom;
            rst = (r[5:0] == 6'd0);
            r   = $urandom; a1 = r[0:0]; b1 = r[1:1]; a8 = r[15:8]; b8 = r[23:16];
            r   = $urandom; a13 = r[12:0]; b13 = r[28:16];
            r   = $urandom; a32 = r;
            r   = $urandom; b32 = r;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/au_add_core.md
Name: au_add_core

Overview:
- Parameterized two-operand binary adder with a selectable carry-propagation architecture.
- Computes the sum modulo 2^WIDTH and registers it at the output; no carry-in.
- Arithmetic leaf block inside the arithmetic-unit library, used wherever a wrap-around add is needed.
- Every ARCH value must produce bit-identical results; ARCH changes only the internal structure.

Parameters:
- WIDTH, 8, operand and sum word length in bits; legal range 1..64.
- ARCH, 0, carry architecture:
  - 0 = ripple-carry
  - 1 = Sklansky parallel prefix
  - 2 = Kogge-Stone parallel prefix
  - 3 = Brent-Kung parallel prefix
  - any other value = ripple-carry

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  augend, unsigned (two's-complement compatible).
- b  input  WIDTH  addend, unsigned (two's-complement compatible).
- s  output  WIDTH  registered sum, (a + b) mod 2^WIDTH.

Behaviour:
- Reset:
  - Synchronous and active-high.
  - On a rising clk edge with rst=1, s becomes 0, whatever a and b are.
  - If rst is asserted mid-stream, the result captured on that edge is discarded.
- Latency:
  - Exactly 1 cycle; no handshake, and a new operand pair is accepted every cycle.
  - On each rising edge with rst=0, s takes (a + b) mod 2^WIDTH, using the a and b present just before that edge.
  - s holds its value between edges.
- Arithmetic:
  - Full-width add with no carry-in.
  - The carry out of bit WIDTH-1 is discarded in the base build.
  - Overflow wraps: all-ones + 1 = 0, and all-ones + all-ones = all-ones minus 1 (0xFE for WIDTH=8).
- Datapath:
  - Combinational from a/b to the output register.
  - Bitwise generate g = a&b and propagate p = a^b.
  - The ARCH-selected network produces carries c[i] into each bit i, with c[0] = 0.
  - Sum: s_next[i] = p[i] ^ c[i].
- Prefix networks:
  - Use the associative (g,p) combine operator: (gH | pH&gL, pH&pL).
  - Sklansky: log2 levels with divide-and-conquer fan-out.
  - Kogge-Stone: log2 levels with span doubling per level.
  - Brent-Kung: an up-sweep followed by a down-sweep.
  - All three must handle non-power-of-2 WIDTH by pruning out-of-range nodes.
  - WIDTH=1 degenerates to s_next = a ^ b for every ARCH.
- X handling: no X may appear on s after reset when a and b are known.
- Structure: no other state besides the output register(s).

Optional Feature:
- Macro: AU_ADD_COUT_EN.
- When defined:
  - Adds output port co (1 bit), placed after s.
  - co is the registered carry out of bit WIDTH-1, i.e. bit WIDTH of a + b.
  - co has the same 1-cycle latency as s and resets to 0 together with s.
- When undefined:
  - The co port does not exist.
  - The final carry is not computed beyond what the sum requires.

Test Plan:
- Reset: drive a=0xA5, b=0x3C with rst=1 for 2 edges -> s=0x00 (co=0). Deassert rst -> s=0xE1 one edge later.
- Exhaustive check, WIDTH=8, each ARCH 0..3 (optionally also ARCH=7):
  - Apply all 65536 (a,b) pairs, one per cycle.
  - Compare s with (a+b) mod 256, delayed by one cycle.
  - Required: zero mismatches.
- Corner values, WIDTH=8, every ARCH:
  - 0x00+0x00 -> 0x00 (co=0)
  - 0x00+0xFF -> 0xFF (co=0)
  - 0xFF+0x00 -> 0xFF (co=0)
  - 0xFF+0xFF -> 0xFE (co=1)
  - 0xFF+0x01 -> 0x00 (co=1)
- Wide random, WIDTH=32 and WIDTH=13 (non-power-of-2), every ARCH:
  - 4 all-zero/all-one corner pairs, then 10000 random pairs.
  - Required: s equals the model sum one cycle later, and all ARCH variants agree bit-for-bit.
- Back-to-back streaming, WIDTH=8:
  - Inputs (0x01,0x02), (0x80,0x80), (0x7F,0x01) on consecutive cycles -> s = 0x03, 0x00, 0x80 on the following consecutive cycles.
  - Assert rst in the middle of the sequence -> s=0x00 on that edge, then the stream resumes.
- Degenerate WIDTH=1, all ARCH:
  - (0,0)->0, (0,1)->1, (1,0)->1, (1,1)->0 (co=1 for the (1,1) case).
